// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_pkg
// Purpose  : Shared definitions for the control pipeline: bundle bit indices,
//            PC-source and forwarding encodings, bubble constants and the
//            bundle typedefs.
// Revision : 1.0  initial release
// ============================================================================
package ctrl_pkg;

    // Bundle widths
    localparam int WB_W = 2;
    localparam int M_W  = 4;
    localparam int EX_W = 5;

    // WB bundle bit positions
    localparam int WB_REGWRITE = 0;
    localparam int WB_MEMTOREG = 1;

    // M bundle bit positions
    localparam int M_BRANCH   = 0;
    localparam int M_MEMREAD  = 1;
    localparam int M_MEMWRITE = 2;
    localparam int M_JUMP     = 3;

    // EX bundle bit positions
    localparam int EX_REGDST   = 0;
    localparam int EX_ALUOP_LO = 1;
    localparam int EX_ALUOP_HI = 3;
    localparam int EX_ALUSRC   = 4;

    // Bundle types
    typedef logic [WB_W-1:0] wb_bundle_t;
    typedef logic [M_W-1:0]  m_bundle_t;
    typedef logic [EX_W-1:0] ex_bundle_t;

    // PC source select encodings
    localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
    localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    // ALU operand forwarding encodings
    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_EXMEM   = 2'b10;
    localparam logic [1:0] FWD_MEMWB   = 2'b01;

    // A bubble never writes the regfile or memory and never redirects
    localparam wb_bundle_t BUBBLE_WB = '0;
    localparam m_bundle_t  BUBBLE_M  = '0;
    localparam ex_bundle_t BUBBLE_EX = '0;

endpackage
`default_nettype wire

// File: rtl/control_pipeline_hazard_forward_unit.sv
`default_nettype none
// ============================================================================
// Module   : hazard_forward_unit
// Purpose  : Combinational hazard logic: load-use stall detection, MEM-stage
//            redirect resolution (jump beats branch) and EX-stage operand
//            forwarding selects with EX/MEM priority over MEM/WB.
// Revision : 1.0  initial release
// ============================================================================
module hazard_forward_unit
    import ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter bit FWD_EN     = 1'b1
) (
    input  logic                  i_ex_memread,
    input  logic [REG_ADDR_W-1:0] i_ex_rs,
    input  logic [REG_ADDR_W-1:0] i_ex_rt,
    input  logic [REG_ADDR_W-1:0] i_id_rs,
    input  logic [REG_ADDR_W-1:0] i_id_rt,
    input  logic                  i_mem_branch,
    input  logic                  i_mem_jump,
    input  logic                  i_mem_zero,
    input  logic                  i_mem_regwrite,
    input  logic [REG_ADDR_W-1:0] i_mem_rd,
    input  logic                  i_wb_regwrite,
    input  logic [REG_ADDR_W-1:0] i_wb_rd,
    output logic                  o_stall,
    output logic                  o_take,
    output logic [1:0]            o_pc_src,
    output logic [1:0]            o_fwd_a,
    output logic [1:0]            o_fwd_b
);

    // Nearest producer wins; register 0 is hard-wired and never forwards
    function automatic logic [1:0] fwd_sel(
        input logic                  mem_we,
        input logic [REG_ADDR_W-1:0] mem_rd,
        input logic                  wb_we,
        input logic [REG_ADDR_W-1:0] wb_rd,
        input logic [REG_ADDR_W-1:0] src
    );
        logic [1:0] sel;
        sel = FWD_REGFILE;
        if (mem_we && (mem_rd != '0) && (mem_rd == src)) begin
            sel = FWD_EXMEM;
        end else if (wb_we && (wb_rd != '0) && (wb_rd == src)) begin
            sel = FWD_MEMWB;
        end
        return sel;
    endfunction

    // Load in EX whose target is read by the instruction in ID; rt compared even for I-type
    always_comb begin
        o_stall = i_ex_memread && (i_ex_rt != '0) &&
                  ((i_ex_rt == i_id_rs) || (i_ex_rt == i_id_rt));
    end

    // Redirect resolved in MEM; jump takes precedence over branch
    always_comb begin
        o_take   = i_mem_jump || (i_mem_branch && i_mem_zero);
        o_pc_src = PC_SRC_SEQ;
        if (o_take) begin
            o_pc_src = i_mem_jump ? PC_SRC_JUMP : PC_SRC_BRANCH;
        end
    end

    generate
        if (FWD_EN) begin : g_fwd_on
            // Per-operand forwarding select for the instruction in EX
            always_comb begin
                o_fwd_a = fwd_sel(i_mem_regwrite, i_mem_rd, i_wb_regwrite, i_wb_rd, i_ex_rs);
                o_fwd_b = fwd_sel(i_mem_regwrite, i_mem_rd, i_wb_regwrite, i_wb_rd, i_ex_rt);
            end
        end else begin : g_fwd_off
            assign o_fwd_a = FWD_REGFILE;
            assign o_fwd_b = FWD_REGFILE;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/control_pipeline.sv
`default_nettype none
// ============================================================================
// Module   : control_pipeline
// Purpose  : Carries decoder control bundles through ID/EX, EX/MEM and MEM/WB,
//            sanitises bundles on capture, inserts load-use bubbles, flushes
//            on MEM-stage redirects and drives EX-stage forwarding selects.
// Revision : 1.0  initial release
// ============================================================================
module control_pipeline
    import ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter bit FWD_EN     = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            id_wb,
    input  logic [3:0]            id_m,
    input  logic [4:0]            id_ex,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  ex_zero,
    output logic                  pc_write,
    output logic                  ifid_write,
    output logic                  ifid_flush,
    output logic [1:0]            pc_src,
    output logic [4:0]            ex_ex,
    output logic [3:0]            mem_m,
    output logic [1:0]            wb_wb,
    output logic [REG_ADDR_W-1:0] mem_rd,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b
);

    // ID/EX
    wb_bundle_t            r_ex_wb;
    m_bundle_t             r_ex_m;
    ex_bundle_t            r_ex_ex;
    logic [REG_ADDR_W-1:0] r_ex_rs;
    logic [REG_ADDR_W-1:0] r_ex_rt;
    logic [REG_ADDR_W-1:0] r_ex_rd;
    // EX/MEM
    wb_bundle_t            r_mem_wb;
    m_bundle_t             r_mem_m;
    logic [REG_ADDR_W-1:0] r_mem_rd;
    logic                  r_mem_zero;
    // MEM/WB
    wb_bundle_t            r_wb_wb;
    logic [REG_ADDR_W-1:0] r_wb_rd;

    wb_bundle_t w_cap_wb;
    m_bundle_t  w_cap_m;
    ex_bundle_t w_cap_ex;
    logic       w_stall;
    logic       w_take;
    logic [1:0] w_pc_src;

    // Clean the decoder bundle so don't-care fields of non-writing or jump ops never get stored
    always_comb begin
        w_cap_wb = id_wb;
        w_cap_m  = id_m;
        w_cap_ex = id_ex;
        if (!id_wb[WB_REGWRITE]) begin
            w_cap_wb[WB_MEMTOREG] = 1'b0;
            w_cap_ex[EX_REGDST]   = 1'b0;
        end
        if (id_m[M_JUMP]) begin
            w_cap_ex = BUBBLE_EX;
        end
    end

    hazard_forward_unit #(
        .REG_ADDR_W (REG_ADDR_W),
        .FWD_EN     (FWD_EN)
    ) u_hazard_forward_unit (
        .i_ex_memread   (r_ex_m[M_MEMREAD]),
        .i_ex_rs        (r_ex_rs),
        .i_ex_rt        (r_ex_rt),
        .i_id_rs        (id_rs),
        .i_id_rt        (id_rt),
        .i_mem_branch   (r_mem_m[M_BRANCH]),
        .i_mem_jump     (r_mem_m[M_JUMP]),
        .i_mem_zero     (r_mem_zero),
        .i_mem_regwrite (r_mem_wb[WB_REGWRITE]),
        .i_mem_rd       (r_mem_rd),
        .i_wb_regwrite  (r_wb_wb[WB_REGWRITE]),
        .i_wb_rd        (r_wb_rd),
        .o_stall        (w_stall),
        .o_take         (w_take),
        .o_pc_src       (w_pc_src),
        .o_fwd_a        (fwd_a),
        .o_fwd_b        (fwd_b)
    );

    // ID/EX: bubble on reset, redirect or load-use stall, otherwise capture the cleaned bundle
    always_ff @(posedge clk) begin
        if (!rst_n || w_take || w_stall) begin
            r_ex_wb <= BUBBLE_WB;
            r_ex_m  <= BUBBLE_M;
            r_ex_ex <= BUBBLE_EX;
            r_ex_rs <= '0;
            r_ex_rt <= '0;
            r_ex_rd <= '0;
        end else begin
            r_ex_wb <= w_cap_wb;
            r_ex_m  <= w_cap_m;
            r_ex_ex <= w_cap_ex;
            r_ex_rs <= id_rs;
            r_ex_rt <= id_rt;
            r_ex_rd <= id_rd;
        end
    end

    // EX/MEM: advances through a stall, squashed by a redirect
    always_ff @(posedge clk) begin
        if (!rst_n || w_take) begin
            r_mem_wb   <= BUBBLE_WB;
            r_mem_m    <= BUBBLE_M;
            r_mem_rd   <= '0;
            r_mem_zero <= 1'b0;
        end else begin
            r_mem_wb   <= r_ex_wb;
            r_mem_m    <= r_ex_m;
            r_mem_rd   <= r_ex_ex[EX_REGDST] ? r_ex_rd : r_ex_rt;
            r_mem_zero <= ex_zero;
        end
    end

    // MEM/WB: always advances; the redirecting instruction itself retires normally
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wb_wb <= BUBBLE_WB;
            r_wb_rd <= '0;
        end else begin
            r_wb_wb <= r_mem_wb;
            r_wb_rd <= r_mem_rd;
        end
    end

    // Redirect overrides a stall; nothing is enabled while reset is asserted
    assign pc_write   = rst_n & (w_take | ~w_stall);
    assign ifid_write = rst_n & (w_take | ~w_stall);
    assign ifid_flush = rst_n & w_take;
    assign pc_src     = rst_n ? w_pc_src : PC_SRC_SEQ;

    assign ex_ex  = r_ex_ex;
    assign mem_m  = r_mem_m;
    assign wb_wb  = r_wb_wb;
    assign mem_rd = r_mem_rd;
    assign wb_rd  = r_wb_rd;

endmodule
`default_nettype wire

// File: tb/tb_control_pipeline.sv
`default_nettype none
// ============================================================================
// Module   : tb_control_pipeline
// Purpose  : Directed self-checking bench for control_pipeline. The bench
//            plays the IF/ID register, holding or clearing the ID fields as
//            the pipeline control outputs demand.
// Revision : 1.0  initial release
// ============================================================================
module tb_control_pipeline;

    logic       clk;
    logic       rst_n;
    logic [1:0] id_wb;
    logic [3:0] id_m;
    logic [4:0] id_ex;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic [4:0] id_rd;
    logic       ex_zero;
    logic       pc_write;
    logic       ifid_write;
    logic       ifid_flush;
    logic [1:0] pc_src;
    logic [4:0] ex_ex;
    logic [3:0] mem_m;
    logic [1:0] wb_wb;
    logic [4:0] mem_rd;
    logic [4:0] wb_rd;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;

    int errors = 0;
    int checks = 0;

    // Decoder bundles: {wb, m, ex}
    localparam logic [1:0] WB_ALU = 2'b01;
    localparam logic [1:0] WB_LD  = 2'b11;
    localparam logic [4:0] EX_R   = 5'b00101;
    localparam logic [4:0] EX_LS  = 5'b10000;
    localparam logic [4:0] EX_BEQ = 5'b00010;

    control_pipeline #(
        .REG_ADDR_W (5),
        .FWD_EN     (1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .id_wb      (id_wb),
        .id_m       (id_m),
        .id_ex      (id_ex),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_rd      (id_rd),
        .ex_zero    (ex_zero),
        .pc_write   (pc_write),
        .ifid_write (ifid_write),
        .ifid_flush (ifid_flush),
        .pc_src     (pc_src),
        .ex_ex      (ex_ex),
        .mem_m      (mem_m),
        .wb_wb      (wb_wb),
        .mem_rd     (mem_rd),
        .wb_rd      (wb_rd),
        .fwd_a      (fwd_a),
        .fwd_b      (fwd_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [1:0] wb, input logic [3:0] m, input logic [4:0] ex,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        id_wb = wb;
        id_m  = m;
        id_ex = ex;
        id_rs = rs;
        id_rt = rt;
        id_rd = rd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        drive(2'b00, 4'b0000, 5'b00000, 5'd0, 5'd0, 5'd0);
    endtask

    initial begin
        rst_n   = 1'b0;
        ex_zero = 1'b0;
        nop();

        // Reset held low for three edges
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_pc_write", pc_write, 1'b0);
            check("rst_ifid_write", ifid_write, 1'b0);
        end
        rst_n = 1'b1;
        #1;
        check("empty_pc_write", pc_write, 1'b1);
        check("empty_ifid_write", ifid_write, 1'b1);
        check("empty_ex_ex", ex_ex, 5'd0);
        check("empty_mem_m", mem_m, 4'd0);
        check("empty_wb_wb", wb_wb, 2'd0);
        check("empty_pc_src", pc_src, 2'd0);
        check("empty_flush", ifid_flush, 1'b0);
        check("empty_fwd_a", fwd_a, 2'd0);

        // LW r2,(r1) followed by ADD r3,r2,r4: one stall cycle, then MEM/WB forward
        drive(WB_LD, 4'b0010, EX_LS, 5'd1, 5'd2, 5'd0);
        #1;
        check("lu_lw_no_stall", pc_write, 1'b1);
        tick();
        drive(WB_ALU, 4'b0000, EX_R, 5'd2, 5'd4, 5'd3);
        #1;
        check("lu_stall_pc_write", pc_write, 1'b0);
        check("lu_stall_ifid_write", ifid_write, 1'b0);
        tick();
        check("lu_bubble_ex_ex", ex_ex, 5'd0);
        check("lu_stall_once", pc_write, 1'b1);
        tick();
        check("lu_add_ex_ex", ex_ex, EX_R);
        check("lu_fwd_a", fwd_a, 2'b01);
        check("lu_fwd_b", fwd_b, 2'b00);
        check("lu_wb_rd", wb_rd, 5'd2);
        check("lu_wb_wb", wb_wb, WB_LD);

        // ADD r5 then SUB r6,r5,r5: both operands from EX/MEM
        drive(WB_ALU, 4'b0000, EX_R, 5'd1, 5'd2, 5'd5);
        tick();
        drive(WB_ALU, 4'b0000, EX_R, 5'd5, 5'd5, 5'd6);
        tick();
        check("exmem_fwd_a", fwd_a, 2'b10);
        check("exmem_fwd_b", fwd_b, 2'b10);
        check("exmem_mem_rd", mem_rd, 5'd5);

        // Writer of r0 never forwards
        drive(WB_ALU, 4'b0000, EX_R, 5'd1, 5'd2, 5'd0);
        tick();
        drive(WB_ALU, 4'b0000, EX_R, 5'd0, 5'd0, 5'd7);
        tick();
        check("r0_fwd_a", fwd_a, 2'b00);
        check("r0_fwd_b", fwd_b, 2'b00);

        // r8 written by both MEM and WB stages: EX/MEM wins
        drive(WB_ALU, 4'b0000, EX_R, 5'd1, 5'd2, 5'd8);
        tick();
        drive(WB_ALU, 4'b0000, EX_R, 5'd1, 5'd2, 5'd8);
        tick();
        drive(WB_ALU, 4'b0000, EX_R, 5'd8, 5'd9, 5'd9);
        tick();
        check("prio_fwd_a", fwd_a, 2'b10);
        check("prio_fwd_b", fwd_b, 2'b00);

        nop();
        tick();
        tick();
        tick();

        // BEQ taken: redirect two cycles after EX, then two bubbles
        drive(2'b00, 4'b0001, EX_BEQ, 5'd1, 5'd2, 5'd0);
        tick();
        ex_zero = 1'b1;
        drive(WB_ALU, 4'b0000, EX_R, 5'd1, 5'd2, 5'd10);
        #1;
        check("beq_not_yet", pc_src, 2'b00);
        tick();
        ex_zero = 1'b0;
        drive(WB_ALU, 4'b0000, EX_R, 5'd1, 5'd2, 5'd11);
        #1;
        check("beq_pc_src", pc_src, 2'b01);
        check("beq_flush", ifid_flush, 1'b1);
        check("beq_pc_write", pc_write, 1'b1);
        tick();
        check("beq_bub_ex_ex", ex_ex, 5'd0);
        check("beq_bub1_mem_m", mem_m, 4'd0);
        nop();
        #1;
        check("beq_after_pc_src", pc_src, 2'b00);
        check("beq_after_flush", ifid_flush, 1'b0);
        tick();
        check("beq_bub2_mem_m", mem_m, 4'd0);
        check("beq_bub1_wb_we", wb_wb[0], 1'b0);
        tick();
        check("beq_bub2_wb_we", wb_wb[0], 1'b0);

        // BEQ not taken
        drive(2'b00, 4'b0001, EX_BEQ, 5'd1, 5'd2, 5'd0);
        tick();
        nop();
        tick();
        #1;
        check("beqnt_mem_m", mem_m, 4'b0001);
        check("beqnt_pc_src", pc_src, 2'b00);
        check("beqnt_flush", ifid_flush, 1'b0);
        tick();

        // J (with branch bit too) arriving in MEM while a load-use stall is pending
        drive(2'b00, 4'b1001, 5'b11111, 5'd0, 5'd0, 5'd0);
        tick();
        check("j_ex_ex_zero", ex_ex, 5'd0);
        ex_zero = 1'b1;
        drive(WB_LD, 4'b0010, EX_LS, 5'd1, 5'd12, 5'd0);
        tick();
        ex_zero = 1'b0;
        drive(WB_ALU, 4'b0000, EX_R, 5'd12, 5'd3, 5'd13);
        #1;
        check("j_pc_write", pc_write, 1'b1);
        check("j_ifid_write", ifid_write, 1'b1);
        check("j_pc_src", pc_src, 2'b10);
        check("j_flush", ifid_flush, 1'b1);
        tick();
        check("j_bub_ex_ex", ex_ex, 5'd0);
        check("j_bub_mem_m", mem_m, 4'd0);
        nop();
        tick();

        // SW with don't-care WB/RegDst bits
        drive(2'bx0, 4'b0100, 5'b1000x, 5'd1, 5'd13, 5'd31);
        tick();
        check("sw_ex_ex", ex_ex, EX_LS);
        nop();
        tick();
        check("sw_mem_m", mem_m, 4'b0100);
        check("sw_mem_rd", mem_rd, 5'd13);
        check("sw_mem_rd_known", $isunknown(mem_rd), 1'b0);
        tick();
        check("sw_wb_wb", wb_wb, 2'b00);

        // Second SW, reset asserted while it sits in MEM
        drive(2'bx0, 4'b0100, 5'b1000x, 5'd1, 5'd14, 5'd0);
        tick();
        nop();
        tick();
        check("swr_mem_m", mem_m, 4'b0100);
        rst_n = 1'b0;
        #1;
        check("swr_pc_write", pc_write, 1'b0);
        check("swr_pc_src", pc_src, 2'b00);
        tick();
        check("swr_mem_m_cleared", mem_m, 4'd0);
        check("swr_wb_wb_cleared", wb_wb, 2'd0);
        check("swr_ex_ex_cleared", ex_ex, 5'd0);
        rst_n = 1'b1;
        #1;
        check("swr_post_pc_write", pc_write, 1'b1);
        check("swr_post_ifid_write", ifid_write, 1'b1);
        check("swr_post_fwd_a", fwd_a, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
